// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle add/sub/and/not-B/shifts, n-cycle shift-add unsigned multiply.
// Latency: 1 cycle for non-mul ops (done at the accepting edge), n cycles for mul.
// Backpressure: ready is low while a multiply is in flight; start is ignored then.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, ALUop        request and op select (000 add, 001 sub, 010 and, 011 not-B,
//                       100 mul, 101 lsl, 110 lsr, 111 asr)
//   Ain, Bin            operands; Bin[clog2(n)-1:0] is the shift amount for shifts
//   ready, done         idle indicator, one-cycle completion pulse
//   ALUout, status      registered result and flags {ovf, neg, zero}
module mc_alu #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] Ain,
    input  logic [n-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic         ready,
    output logic         done,
    output logic [n-1:0] ALUout,
    output logic [2:0]   status
);

    localparam int sw = $clog2(n);
    localparam logic [sw-1:0] cnt_last = sw'(n - 1);

    localparam logic [2:0] op_add = 3'b000;
    localparam logic [2:0] op_sub = 3'b001;
    localparam logic [2:0] op_and = 3'b010;
    localparam logic [2:0] op_notb = 3'b011;
    localparam logic [2:0] op_mul = 3'b100;
    localparam logic [2:0] op_lsl = 3'b101;
    localparam logic [2:0] op_lsr = 3'b110;
    localparam logic [2:0] op_asr = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state_q, state_d;
    logic [sw-1:0]  cnt_q;
    logic [2*n-1:0] mcand_q;
    logic [2*n-1:0] prod_q;
    logic [2*n-1:0] prod_nxt;
    logic [n-1:0]   mplier_q;

    logic           alu_acc;
    logic           mul_acc;
    logic           mul_fin;

    logic           is_sub;
    logic [n-1:0]   b_op;
    logic [n:0]     sum;
    logic           c_msb;
    logic [sw-1:0]  sh;
    logic           sh_big;
    logic [n-1:0]   op_res;
    logic           op_ovf;

    // FSM next state and handshake decode; ready depends on state only.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        alu_acc = 1'b0;
        mul_acc = 1'b0;
        mul_fin = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    if (ALUop == op_mul) begin
                        mul_acc = 1'b1;
                        state_d = MUL;
                    end else begin
                        alu_acc = 1'b1;
                    end
                end
            end
            MUL: begin
                // Last multiplier bit is consumed on this edge.
                if (cnt_q == cnt_last) begin
                    mul_fin = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle datapath. Overflow for add/sub is carry-in(MSB) ^ carry-out(MSB).
    always_comb begin
        is_sub = (ALUop == op_sub);
        b_op   = is_sub ? ~Bin : Bin;
        sum    = {1'b0, Ain} + {1'b0, b_op} + {{n{1'b0}}, is_sub};
        c_msb  = Ain[n-1] ^ b_op[n-1] ^ sum[n-1];
        sh     = Bin[sw-1:0];
        // Only reachable when n is not a power of two.
        sh_big = (32'(sh) >= 32'(n));
        op_res = '0;
        op_ovf = 1'b0;
        case (ALUop)
            op_add, op_sub: begin
                op_res = sum[n-1:0];
                op_ovf = c_msb ^ sum[n];
            end
            op_and:  op_res = Ain & Bin;
            op_notb: op_res = ~Bin;
            op_lsl:  op_res = sh_big ? '0 : (Ain << sh);
            op_lsr:  op_res = sh_big ? '0 : (Ain >> sh);
            op_asr:  op_res = sh_big ? {n{Ain[n-1]}} : $unsigned($signed(Ain) >>> sh);
            default: op_res = '0;
        endcase
    end

    // Shift-add step: product including the current multiplier bit.
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ALUout   <= '0;
            status   <= 3'b000;
            done     <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q <= state_d;
            done    <= alu_acc | mul_fin;

            if (alu_acc) begin
                ALUout <= op_res;
                status <= {op_ovf, op_res[n-1], ~|op_res};
            end

            if (mul_acc) begin
                mcand_q  <= {{n{1'b0}}, Ain};
                mplier_q <= Bin;
                prod_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == MUL) begin
                prod_q   <= prod_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + sw'(1);
            end

            if (mul_fin) begin
                ALUout <= prod_nxt[n-1:0];
                status <= {|prod_nxt[2*n-1:n], prod_nxt[n-1], ~|prod_nxt[n-1:0]};
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;

    localparam int n = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [n-1:0] Ain;
    logic [n-1:0] Bin;
    logic [2:0]   ALUop;
    logic         ready;
    logic         done;
    logic [n-1:0] ALUout;
    logic [2:0]   status;

    int total = 0;
    int bad   = 0;

    mc_alu #(.n(n)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Ain    (Ain),
        .Bin    (Bin),
        .ALUop  (ALUop),
        .ready  (ready),
        .done   (done),
        .ALUout (ALUout),
        .status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [n-1:0] a, input logic [n-1:0] b);
        start = 1'b1;
        ALUop = op;
        Ain   = a;
        Bin   = b;
    endtask

    // One single-cycle op: drive on a falling edge, check right after the accepting edge.
    task automatic single(input string tag, input logic [2:0] op, input logic [n-1:0] a,
                          input logic [n-1:0] b, input logic [n-1:0] eo, input logic [2:0] es);
        @(negedge clk);
        issue(op, a, b);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_out"}, 32'(ALUout), 32'(eo));
        check({tag, "_st"}, 32'(status), 32'(es));
    endtask

    // Multiply with optional start/reset injection at sample j (j = edges after accept).
    // Runs a fixed window; lat stays -1 if done never appears.
    task automatic run_mul(input logic [n-1:0] a, input logic [n-1:0] b,
                           input int inj_start, input int inj_reset,
                           output int lat, output int rdylow, output int ndone,
                           output logic rdy_after_rst);
        lat = -1;
        rdylow = 0;
        ndone = 0;
        rdy_after_rst = 1'b0;
        @(negedge clk);
        issue(3'b100, a, b);
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (j == 0 || j == inj_start + 1) start = 1'b0;
            if (j == inj_reset + 1) begin
                rdy_after_rst = ready;
                reset = 1'b0;
            end
            if (done) begin
                if (ndone == 0) lat = j;
                ndone++;
            end else if (ndone == 0 && !ready) begin
                rdylow++;
            end
            if (j == inj_start) issue(3'b000, 16'h0001, 16'h0001);
            if (j == inj_reset) reset = 1'b1;
        end
    endtask

    int   lat, rdylow, ndone;
    logic rar;

    initial begin
        // Reset with a start request in the same cycle: the request must be dropped.
        reset = 1'b1;
        issue(3'b000, 16'h0002, 16'h0003);
        repeat (2) @(negedge clk);
        check("rst_done_w_start", 32'(done), 32'd0);
        check("rst_out_w_start", 32'(ALUout), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", 32'(ALUout), 32'd0);
        check("rst_st", 32'(status), 32'd0);

        single("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b110);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("hold_out", 32'(ALUout), 32'h8000);

        // Back-to-back sub then and.
        @(negedge clk);
        issue(3'b001, 16'h0005, 16'h0005);
        @(negedge clk);
        check("sub_done", 32'(done), 32'd1);
        check("sub_out", 32'(ALUout), 32'h0000);
        check("sub_st", 32'(status), 32'(3'b001));
        issue(3'b010, 16'h00F0, 16'h0FF0);
        @(negedge clk);
        start = 1'b0;
        check("and_done", 32'(done), 32'd1);
        check("and_out", 32'(ALUout), 32'h00F0);
        check("and_st", 32'(status), 32'(3'b000));

        single("notb", 3'b011, 16'h1234, 16'h00FF, 16'hFF00, 3'b010);
        single("sub_ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 3'b100);
        single("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b001);
        single("asr", 3'b111, 16'h8000, 16'h0004, 16'hF800, 3'b010);
        single("lsr", 3'b110, 16'h8000, 16'h0004, 16'h0800, 3'b000);
        single("lsl", 3'b101, 16'h0001, 16'h000F, 16'h8000, 3'b010);

        run_mul(16'h0003, 16'h0005, -10, -10, lat, rdylow, ndone, rar);
        check("mul35_lat", 32'(lat), 32'd16);
        check("mul35_rdylow", 32'(rdylow), 32'd16);
        check("mul35_ndone", 32'(ndone), 32'd1);
        check("mul35_out", 32'(ALUout), 32'h000F);
        check("mul35_st", 32'(status), 32'(3'b000));

        run_mul(16'h0100, 16'h0100, -10, -10, lat, rdylow, ndone, rar);
        check("mul_big_out", 32'(ALUout), 32'h0000);
        check("mul_big_st", 32'(status), 32'(3'b101));

        run_mul(16'h0007, 16'h0009, 4, -10, lat, rdylow, ndone, rar);
        check("mul79_lat", 32'(lat), 32'd16);
        check("mul79_ndone", 32'(ndone), 32'd1);
        check("mul79_out", 32'(ALUout), 32'h003F);
        check("mul79_st", 32'(status), 32'(3'b000));

        run_mul(16'h0007, 16'h0009, -10, 7, lat, rdylow, ndone, rar);
        check("abort_ndone", 32'(ndone), 32'd0);
        check("abort_ready", 32'(rar), 32'd1);
        check("abort_out", 32'(ALUout), 32'h0000);
        check("abort_st", 32'(status), 32'(3'b000));

        single("add_after_abort", 3'b000, 16'h0002, 16'h0003, 16'h0005, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
